// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants for the register file slice
package cpu_defs;

  localparam int REG_NUM = 32;
  localparam int CPU_ADDR_W = $clog2(REG_NUM);
  localparam int CPU_DATA_W = 32;
  localparam logic [CPU_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_trace_reg.sv
// rtl/gpr_trace_reg.sv - registered one-cycle retirement trace (debug_wb_*)
module gpr_trace_reg
  import cpu_defs::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_w_reg_ena,
  input  logic [ADDR_W-1:0] wb_w_reg_addr,
  input  logic [DATA_W-1:0] wb_w_reg_data,
  input  logic [31:0]       wb_pc,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  logic real_write;
  assign real_write = wb_w_reg_ena && (wb_w_reg_addr != ADDR_W'(REG_ZERO));

  // pc/wnum/wdata hold across idle cycles so the last retirement stays visible
  always_ff @(posedge clk) begin
    if (rst) begin
      debug_wb_pc       <= RESET_PC;
      debug_wb_rf_wen   <= 4'h0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (wb_valid) begin
      debug_wb_pc       <= wb_pc;
      debug_wb_rf_wen   <= {4{real_write}};
      debug_wb_rf_wnum  <= wb_w_reg_addr;
      debug_wb_rf_wdata <= wb_w_reg_data;
    end else begin
      debug_wb_rf_wen   <= 4'h0;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - 32x32 MIPS register file with write->read bypass and retirement trace
module gpr_file
  import cpu_defs::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_w_reg_ena,
  input  logic [ADDR_W-1:0] wb_w_reg_addr,
  input  logic [DATA_W-1:0] wb_w_reg_data,
  input  logic [31:0]       wb_pc,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] r_addr_a,
  output logic [DATA_W-1:0] r_data_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_b,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr [DEPTH];

  // Index 0 is cleared on reset and never written, so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr[i] <= '0;
      end
    end else if (wb_w_reg_ena && (wb_w_reg_addr != ADDR_W'(REG_ZERO))) begin
      gpr[wb_w_reg_addr] <= wb_w_reg_data;
    end
  end

  always_comb begin
    r_data_a = gpr[r_addr_a];
    if (r_addr_a == ADDR_W'(REG_ZERO)) begin
      r_data_a = '0;
    end else if (wb_w_reg_ena && (wb_w_reg_addr == r_addr_a)) begin
      r_data_a = wb_w_reg_data;
    end
  end

  always_comb begin
    r_data_b = gpr[r_addr_b];
    if (r_addr_b == ADDR_W'(REG_ZERO)) begin
      r_data_b = '0;
    end else if (wb_w_reg_ena && (wb_w_reg_addr == r_addr_b)) begin
      r_data_b = wb_w_reg_data;
    end
  end

  gpr_trace_reg #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_trace (
    .clk               (clk),
    .rst               (rst),
    .wb_valid          (wb_valid),
    .wb_w_reg_ena      (wb_w_reg_ena),
    .wb_w_reg_addr     (wb_w_reg_addr),
    .wb_w_reg_data     (wb_w_reg_data),
    .wb_pc             (wb_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

endmodule
